// File: rtl/enigma_rotor_stepper.sv
// enigma_rotor_stepper
// Rotor-position stage of the Enigma datapath. Accepts one letter code per
// valid/ready handshake, advances the three rotor positions with historical
// stepping (including the middle-rotor double-step), and presents the letter
// together with the positions to use for it in a one-entry output register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load, load_pos_l/m/r  load rotor start positions (values >= 26 load 0)
//   in_valid/in_ready     input handshake, in_char 0..25 = A..Z, 26..31 = non-letter
//   out_valid/out_ready   output handshake
//   out_char, out_bypass  registered letter, bypass flag for non-letters
//   out_pos_l/m/r         rotor positions to encrypt out_char with
//   pos_l/m/r             live rotor positions
//   char_count            letters stepped since reset/load, saturating
module enigma_rotor_stepper #(
  parameter int NOTCH_R = 21,
  parameter int NOTCH_M = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [4:0]       load_pos_l,
  input  logic [4:0]       load_pos_m,
  input  logic [4:0]       load_pos_r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_char,
  output logic             out_bypass,
  output logic [4:0]       out_pos_l,
  output logic [4:0]       out_pos_m,
  output logic [4:0]       out_pos_r,
  output logic [4:0]       pos_l,
  output logic [4:0]       pos_m,
  output logic [4:0]       pos_r,
  output logic [CNT_W-1:0] char_count
);

  localparam logic [4:0] LAST_POS  = 5'd25;
  localparam logic [4:0] NOTCH_R_C = 5'(NOTCH_R);
  localparam logic [4:0] NOTCH_M_C = 5'(NOTCH_M);

  // Advance one position with wrap 25 -> 0.
  function automatic logic [4:0] wrap_inc(input logic [4:0] p);
    return (p >= LAST_POS) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-range load values collapse to position A.
  function automatic logic [4:0] clamp_pos(input logic [4:0] p);
    return (p > LAST_POS) ? 5'd0 : p;
  endfunction

  // Counter increment that holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic       accept;
  logic       is_letter;
  logic       step_m;
  logic       step_l;
  logic [4:0] nxt_l;
  logic [4:0] nxt_m;
  logic [4:0] nxt_r;

  logic       vld_p0;
  logic [4:0] char_p0;
  logic       bypass_p0;
  logic [4:0] opos_l_p0;
  logic [4:0] opos_m_p0;
  logic [4:0] opos_r_p0;

  assign in_ready  = !load && (!vld_p0 || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_letter = (in_char <= LAST_POS);

  // Middle at its notch steps itself and the left rotor (double-step);
  // otherwise the right rotor's notch carries into the middle.
  assign step_l = (pos_m == NOTCH_M_C);
  assign step_m = step_l || (pos_r == NOTCH_R_C);
  assign nxt_r  = wrap_inc(pos_r);
  assign nxt_m  = step_m ? wrap_inc(pos_m) : pos_m;
  assign nxt_l  = step_l ? wrap_inc(pos_l) : pos_l;

  // Stage p0: live rotor state and letter counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_l      <= 5'd0;
      pos_m      <= 5'd0;
      pos_r      <= 5'd0;
      char_count <= '0;
    end else if (load) begin
      pos_l      <= clamp_pos(load_pos_l);
      pos_m      <= clamp_pos(load_pos_m);
      pos_r      <= clamp_pos(load_pos_r);
      char_count <= '0;
    end else if (accept && is_letter) begin
      pos_l      <= nxt_l;
      pos_m      <= nxt_m;
      pos_r      <= nxt_r;
      char_count <= sat_inc(char_count);
    end
  end

  // Stage p0: one-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      char_p0   <= 5'd0;
      bypass_p0 <= 1'b0;
      opos_l_p0 <= 5'd0;
      opos_m_p0 <= 5'd0;
      opos_r_p0 <= 5'd0;
    end else if (accept) begin
      vld_p0    <= 1'b1;
      char_p0   <= in_char;
      bypass_p0 <= !is_letter;
      opos_l_p0 <= is_letter ? nxt_l : pos_l;
      opos_m_p0 <= is_letter ? nxt_m : pos_m;
      opos_r_p0 <= is_letter ? nxt_r : pos_r;
    end else if (out_ready) begin
      vld_p0    <= 1'b0;
    end
  end

  assign out_valid  = vld_p0;
  assign out_char   = char_p0;
  assign out_bypass = bypass_p0;
  assign out_pos_l  = opos_l_p0;
  assign out_pos_m  = opos_m_p0;
  assign out_pos_r  = opos_r_p0;

endmodule
